soc_system_nios2_resetreq_seq: RTL and testbench
================================================

# soc_system_nios2_resetreq_seq

Sequencer that owns the Nios II reset-request PIO and shares it among several requesters (HPS software bridge, watchdog, debug). It arbitrates round-robin among pending requests, writes the PIO's single output bit high through its Avalon-MM slave port, waits for the Nios II `resettaken` acknowledge or a timeout, holds, then writes the bit low and signals completion. It sits between the requesters and the PIO `s1` slave, in the same clock domain as the PIO.

## Interface
- `NREQ`, 2: number of requesters, 1..8.
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent waiting for `resettaken`, at least 2.
- `HOLD_CYCLES`, 16: cycles the request stays asserted after acknowledge or timeout, at least 1.
- `CNT_W`, 16: counter width; must hold max(`TIMEOUT_CYCLES`, `HOLD_CYCLES`).

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  level request per requester; held high until the matching `done` pulse.
- `grant`  out  NREQ  one-hot owner of the current sequence; 0 when idle.
- `done`  out  NREQ  one-cycle completion pulse to the granted requester.
- `timeout_err`  out  1  one-cycle pulse, coincident with `done`, when the sequence timed out.
- `busy`  out  1  high in every state except IDLE.
- `resettaken`  in  1  Nios II reset-taken acknowledge; synchronous to `clk`.
- `pio_address`  out  2  PIO slave address; always 0.
- `pio_chipselect`  out  1  PIO chip select.
- `pio_write_n`  out  1  PIO write strobe, active-low.
- `pio_writedata`  out  32  PIO write data; only bit 0 is meaningful, bits 31:1 are 0.
- `pio_readdata`  in  32  PIO read data; used only when readback is compiled in.

## Operation
- States: IDLE, ASSERT, WAIT_TAKEN, HOLD, DEASSERT, DONE. With readback compiled in, also VERIFY_HI and VERIFY_LO.
- IDLE: if `req` is nonzero, latch a one-hot grant chosen by round-robin, then go to ASSERT.
  - Search starts at the index after the last granted requester.
  - After reset, index 0 has highest priority.
- ASSERT: one cycle with `pio_chipselect`=1, `pio_write_n`=0, `pio_writedata`=1. Next state is WAIT_TAKEN.
- WAIT_TAKEN: the counter clears on entry and increments each cycle.
  - `resettaken`=1 leads to HOLD.
  - The counter reaching `TIMEOUT_CYCLES`-1 without `resettaken` sets a sticky internal timeout flag and leads to HOLD.
- HOLD: the counter clears on entry. Stay for exactly `HOLD_CYCLES` cycles, then go to DEASSERT.
- DEASSERT: one cycle with the write strobe asserted and `pio_writedata`=0. Next state is DONE.
- DONE: for one cycle, `done`=`grant` and `timeout_err`=flag. Grant and flag then clear, and the state returns to IDLE.
- Requests arriving or dropping mid-sequence do not abort it. Non-granted requests wait.
- A `req` still high in the cycle after DONE counts as a new request. It is arbitrated normally, so the other requesters get their turn first.
- `resettaken` pulses outside WAIT_TAKEN are ignored.
- Outside ASSERT, DEASSERT and VERIFY states: `pio_chipselect`=0, `pio_write_n`=1, `pio_writedata`=0.

## Timing
- Reset values: `grant`=0, `done`=0, `timeout_err`=0, `busy`=0, `pio_chipselect`=0, `pio_write_n`=1, `pio_writedata`=0, `pio_address`=0, state IDLE, round-robin pointer so that index 0 is first.
- Reset asserted mid-sequence: all outputs return to their reset values immediately. No DEASSERT write is issued; the PIO relies on its own reset.
- All outputs are registered.
- Latency:
  - `req` sampled high in IDLE at cycle 0: `grant` and the ASSERT write appear in cycle 1.
  - `resettaken` first high at WAIT_TAKEN cycle k: HOLD covers the next `HOLD_CYCLES` cycles, then one DEASSERT cycle, then `done`.
  - Timeout path: `done` comes `TIMEOUT_CYCLES`+`HOLD_CYCLES`+2 cycles after the ASSERT cycle.
- Each requester has at most one sequence outstanding. Worst-case wait is (`NREQ`-1) full sequences.

## Configuration
- `RESETREQ_SEQ_READBACK_EN` defined:
  - VERIFY_HI follows ASSERT and VERIFY_LO follows DEASSERT. Each drives `pio_chipselect`=1, `pio_write_n`=1 for one cycle and samples `pio_readdata[0]` at the end of that cycle.
  - On mismatch, the preceding write is retried once.
  - A second mismatch sets the timeout flag and continues the sequence.
  - Each VERIFY adds 1 cycle; each retry adds 2 more.
- Undefined: no VERIFY states and `pio_readdata` is unused. Behaviour and latency are exactly as described in Operation and Timing.

## Test plan
- Single requester, `req[0]` high, `resettaken` rises 5 cycles after ASSERT, `HOLD_CYCLES`=16 -> exactly one write of 1 and one write of 0, `done[0]` pulse, `timeout_err`=0.
- `resettaken` held low, `TIMEOUT_CYCLES`=64 -> `done` 64+16+2 cycles after ASSERT, with `timeout_err`=1 on the same cycle.
- `req`=2'b11 held continuously -> grants alternate 0,1,0,1. Each requester holds `req` high through its own `done` and the cycle after, which is then arbitrated as a new request.
- Reset asserted during HOLD -> PIO outputs go idle the same cycle, `busy`=0, no DEASSERT write, no `done`. After release, a new `req[1]` gets grant at index 1.
- With `RESETREQ_SEQ_READBACK_EN`, `pio_readdata[0]` forced 0 during the first VERIFY_HI -> ASSERT write repeated once, then the sequence proceeds with `timeout_err`=0 when the retry verifies.

Source files
------------

// File: rtl/soc_system_nios2_resetreq_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : soc_system_nios2_resetreq_seq                              |
// | Description : Shares the Nios II reset-request PIO among NREQ requesters.|
// |               Round-robin arbitration, writes the PIO bit high, waits    |
// |               for resettaken (or a timeout), holds, writes the bit low   |
// |               and pulses done to the owner.                              |
// | Options     : RESETREQ_SEQ_READBACK_EN - read back each PIO write and    |
// |               retry it once on mismatch.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module soc_system_nios2_resetreq_seq #(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int CNT_W          = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] done,
    output logic            timeout_err,
    output logic            busy,
    input  logic            resettaken,
    output logic [1:0]      pio_address,
    output logic            pio_chipselect,
    output logic            pio_write_n,
    output logic [31:0]     pio_writedata,
    input  logic [31:0]     pio_readdata
);

    localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // State encoding
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_ASSERT   = 3'd1;
    localparam logic [2:0] c_ST_WAIT     = 3'd2;
    localparam logic [2:0] c_ST_HOLD     = 3'd3;
    localparam logic [2:0] c_ST_DEASSERT = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;
`ifdef RESETREQ_SEQ_READBACK_EN
    localparam logic [2:0] c_ST_VERIFY_HI = 3'd6;
    localparam logic [2:0] c_ST_VERIFY_LO = 3'd7;
`endif

    // Last counter values of the WAIT_TAKEN and HOLD windows
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    // Sequencer state
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NREQ-1:0]    r_grant;
    logic [NREQ-1:0]    w_grant_nxt;
    logic               r_flag;
    logic               w_flag_nxt;
    logic [c_IDX_W-1:0] r_last_idx;
    logic [c_IDX_W-1:0] w_last_nxt;
`ifdef RESETREQ_SEQ_READBACK_EN
    logic               r_retry;
    logic               w_retry_nxt;
`endif

    // Registered outputs and their next values
    logic [NREQ-1:0]    r_done;
    logic [NREQ-1:0]    w_done_nxt;
    logic               r_terr;
    logic               w_terr_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_cs;
    logic               w_cs_nxt;
    logic               r_wn;
    logic               w_wn_nxt;
    logic               r_wd;
    logic               w_wd_nxt;

    // Round-robin search results
    logic [c_IDX_W-1:0] w_rr_idx;
    logic [NREQ-1:0]    w_rr_onehot;
    logic               w_rr_found;
    int                 v_rr_k;

    // Only bit 0 of the read bus can ever matter
    logic               w_unused_readdata;
    assign w_unused_readdata = ^pio_readdata;

    // Round-robin pick: first requester found after the last granted index
    always_comb begin
        w_rr_idx    = r_last_idx;
        w_rr_onehot = '0;
        w_rr_found  = 1'b0;
        v_rr_k      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            v_rr_k = int'(r_last_idx) + i;
            if (v_rr_k >= NREQ) begin
                v_rr_k = v_rr_k - NREQ;
            end
            if (!w_rr_found && req[c_IDX_W'(v_rr_k)]) begin
                w_rr_found  = 1'b1;
                w_rr_idx    = c_IDX_W'(v_rr_k);
                w_rr_onehot = NREQ'(1) << v_rr_k;
            end
        end
    end

    // Next-state logic of the request sequence
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_flag_nxt  = r_flag;
        w_last_nxt  = r_last_idx;
`ifdef RESETREQ_SEQ_READBACK_EN
        w_retry_nxt = r_retry;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (w_rr_found) begin
                    w_grant_nxt = w_rr_onehot;
                    w_last_nxt  = w_rr_idx;
                    w_flag_nxt  = 1'b0;
`ifdef RESETREQ_SEQ_READBACK_EN
                    w_retry_nxt = 1'b0;
`endif
                    w_state_nxt = c_ST_ASSERT;
                end
            end
            c_ST_ASSERT: begin
`ifdef RESETREQ_SEQ_READBACK_EN
                w_state_nxt = c_ST_VERIFY_HI;
`else
                w_state_nxt = c_ST_WAIT;
`endif
            end
            c_ST_WAIT: begin
                // An acknowledge on the last window cycle still counts
                if (resettaken) begin
                    w_state_nxt = c_ST_HOLD;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
`ifdef RESETREQ_SEQ_READBACK_EN
                    w_retry_nxt = 1'b0;
`endif
                    w_state_nxt = c_ST_DEASSERT;
                end
            end
            c_ST_DEASSERT: begin
`ifdef RESETREQ_SEQ_READBACK_EN
                w_state_nxt = c_ST_VERIFY_LO;
`else
                w_state_nxt = c_ST_DONE;
`endif
            end
            c_ST_DONE: begin
                w_grant_nxt = '0;
                w_flag_nxt  = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
`ifdef RESETREQ_SEQ_READBACK_EN
            c_ST_VERIFY_HI: begin
                if (pio_readdata[0]) begin
                    w_state_nxt = c_ST_WAIT;
                end else if (!r_retry) begin
                    w_retry_nxt = 1'b1;
                    w_state_nxt = c_ST_ASSERT;
                end else begin
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_VERIFY_LO: begin
                if (!pio_readdata[0]) begin
                    w_state_nxt = c_ST_DONE;
                end else if (!r_retry) begin
                    w_retry_nxt = 1'b1;
                    w_state_nxt = c_ST_DEASSERT;
                end else begin
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end
            end
`endif
            default: begin
                w_grant_nxt = '0;
                w_flag_nxt  = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Cycle counter restarts whenever the state changes
    always_comb begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if ((w_state_nxt != r_state) || (r_state == c_ST_IDLE)) begin
            w_cnt_nxt = '0;
        end
    end

    // Output decode from the next state so every output is a plain register
    always_comb begin
        w_busy_nxt = (w_state_nxt != c_ST_IDLE);
        w_cs_nxt   = 1'b0;
        w_wn_nxt   = 1'b1;
        w_wd_nxt   = 1'b0;
        w_done_nxt = '0;
        w_terr_nxt = 1'b0;
        case (w_state_nxt)
            c_ST_ASSERT: begin
                w_cs_nxt = 1'b1;
                w_wn_nxt = 1'b0;
                w_wd_nxt = 1'b1;
            end
            c_ST_DEASSERT: begin
                w_cs_nxt = 1'b1;
                w_wn_nxt = 1'b0;
            end
`ifdef RESETREQ_SEQ_READBACK_EN
            c_ST_VERIFY_HI, c_ST_VERIFY_LO: begin
                w_cs_nxt = 1'b1;
            end
`endif
            c_ST_DONE: begin
                w_done_nxt = w_grant_nxt;
                w_terr_nxt = w_flag_nxt;
            end
            default: begin
                w_cs_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset drops the PIO bus at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_flag     <= 1'b0;
            r_last_idx <= c_IDX_W'(NREQ - 1);
`ifdef RESETREQ_SEQ_READBACK_EN
            r_retry    <= 1'b0;
`endif
            r_done     <= '0;
            r_terr     <= 1'b0;
            r_busy     <= 1'b0;
            r_cs       <= 1'b0;
            r_wn       <= 1'b1;
            r_wd       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_flag     <= w_flag_nxt;
            r_last_idx <= w_last_nxt;
`ifdef RESETREQ_SEQ_READBACK_EN
            r_retry    <= w_retry_nxt;
`endif
            r_done     <= w_done_nxt;
            r_terr     <= w_terr_nxt;
            r_busy     <= w_busy_nxt;
            r_cs       <= w_cs_nxt;
            r_wn       <= w_wn_nxt;
            r_wd       <= w_wd_nxt;
        end
    end

    assign grant          = r_grant;
    assign done           = r_done;
    assign timeout_err    = r_terr;
    assign busy           = r_busy;
    assign pio_address    = 2'b00;
    assign pio_chipselect = r_cs;
    assign pio_write_n    = r_wn;
    assign pio_writedata  = {31'b0, r_wd};

endmodule
`default_nettype wire

// File: tb/tb_soc_system_nios2_resetreq_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_soc_system_nios2_resetreq_seq                           |
// | Description : Self-checking bench for the reset-request sequencer with   |
// |               a sequence-level reference model and random requesters.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_soc_system_nios2_resetreq_seq;

    localparam int NREQ = 3;
    localparam int IW   = 2;
    localparam int T    = 64;
    localparam int H    = 16;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            timeout_err;
    logic            busy;
    logic            resettaken;
    logic [1:0]      pio_address;
    logic            pio_chipselect;
    logic            pio_write_n;
    logic [31:0]     pio_writedata;
    logic [31:0]     pio_readdata;
    logic            pio_reg;

    soc_system_nios2_resetreq_seq #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (T),
        .HOLD_CYCLES    (H),
        .CNT_W          (CW)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .grant          (grant),
        .done           (done),
        .timeout_err    (timeout_err),
        .busy           (busy),
        .resettaken     (resettaken),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural PIO output register
    always @(posedge clk or posedge reset) begin
        if (reset) pio_reg <= 1'b0;
        else if (pio_chipselect && !pio_write_n) pio_reg <= pio_writedata[0];
    end
    assign pio_readdata = {31'b0, pio_reg};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr1_cnt = 0;
    int wr0_cnt = 0;

    // Sequence-level model: owner, cycles since the ASSERT write, and the
    // WAIT cycle on which the wait ended (-1 while still waiting)
    bit m_active;
    int m_owner;
    int m_elapsed;
    int m_wait_end;
    int m_last;
    bit m_to;

    logic [NREQ-1:0] alt_exp [4] = '{3'b001, 3'b010, 3'b001, 3'b010};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_owner    = 0;
        m_elapsed  = 0;
        m_wait_end = -1;
        m_last     = NREQ - 1;
        m_to       = 1'b0;
    endtask

    // Advance the model by one cycle using the inputs of the cycle just ended
    task automatic model_step();
        if (!m_active) begin
            if (req != '0) begin
                for (int i = 1; i <= NREQ; i++) begin
                    int k;
                    k = (m_last + i) % NREQ;
                    if (!m_active && req[IW'(k)]) begin
                        m_active = 1'b1;
                        m_owner  = k;
                    end
                end
                m_last     = m_owner;
                m_elapsed  = 0;
                m_wait_end = -1;
                m_to       = 1'b0;
            end
        end else begin
            if (m_wait_end < 0 && m_elapsed >= 1) begin
                if (resettaken) begin
                    m_wait_end = m_elapsed;
                end else if (m_elapsed == T) begin
                    m_wait_end = T;
                    m_to       = 1'b1;
                end
            end
            m_elapsed++;
            if (m_wait_end >= 0 && m_elapsed == m_wait_end + H + 3) m_active = 1'b0;
        end
    endtask

    task automatic compare();
        logic [NREQ-1:0] eg;
        logic w1, w0, dn;
        eg = m_active ? (NREQ'(1) << m_owner) : '0;
        w1 = m_active && (m_elapsed == 0);
        w0 = m_active && (m_wait_end >= 0) && (m_elapsed == m_wait_end + H + 1);
        dn = m_active && (m_wait_end >= 0) && (m_elapsed == m_wait_end + H + 2);
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), dn ? 32'(eg) : 32'd0);
        chk("timeout_err", 32'(timeout_err), 32'(dn && m_to));
        chk("chipselect", 32'(pio_chipselect), 32'(w1 || w0));
        chk("write_n", 32'(pio_write_n), 32'(!(w1 || w0)));
        chk("writedata", pio_writedata, 32'(w1));
        chk("address", 32'(pio_address), 32'd0);
        if (pio_chipselect && !pio_write_n) begin
            if (pio_writedata[0]) wr1_cnt++;
            else wr0_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        compare();
    endtask

    task automatic go_idle();
        req        = '0;
        resettaken = 1'b0;
        for (int i = 0; i < 300 && (m_active || i < 2); i++) tick();
        chk("idle_bound", 32'(m_active), 32'd0);
    endtask

    // One isolated sequence with a resettaken pulse rt_at cycles after ASSERT
    task automatic run_seq(input string nm, input logic [NREQ-1:0] rq, input int rt_at,
                           input int exp_off, input logic exp_terr, input logic [NREQ-1:0] exp_g);
        int a, dcyc, w1, w0;
        go_idle();
        w1  = wr1_cnt;
        w0  = wr0_cnt;
        req = rq;
        tick();
        a = cyc;
        chk({nm, "_grant"}, 32'(grant), 32'(exp_g));
        chk({nm, "_wr1"}, {29'd0, pio_chipselect, pio_write_n, pio_writedata[0]}, 32'b101);
        dcyc = -1;
        for (int i = 0; i < 400 && dcyc < 0; i++) begin
            resettaken = (rt_at >= 0) && (cyc == a + rt_at);
            tick();
            if (|done) begin
                dcyc = cyc;
                chk({nm, "_done"}, 32'(done), 32'(exp_g));
                chk({nm, "_terr"}, 32'(timeout_err), 32'(exp_terr));
                req = '0;
            end
        end
        resettaken = 1'b0;
        chk({nm, "_latency"}, 32'(dcyc - a), 32'(exp_off));
        chk({nm, "_writes1"}, 32'(wr1_cnt - w1), 32'd1);
        chk({nm, "_writes0"}, 32'(wr0_cnt - w0), 32'd1);
    endtask

    initial begin
        int a, got, rt_mode;
        logic [NREQ-1:0] rq_hold;

        reset      = 1'b1;
        req        = '0;
        resettaken = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs", 32'(pio_chipselect), 32'd0);
        chk("rst_wn", 32'(pio_write_n), 32'd1);
        chk("rst_wd", pio_writedata, 32'd0);
        chk("rst_addr", 32'(pio_address), 32'd0);
        reset = 1'b0;

        // Directed sequences: acknowledge position vs. expected done latency
        run_seq("ack5",      3'b001,  5, 23, 1'b0, 3'b001);
        run_seq("tmo",       3'b100, -1, 82, 1'b1, 3'b100);
        run_seq("ack_last",  3'b010, 64, 82, 1'b0, 3'b010);
        run_seq("ack_first", 3'b001,  1, 19, 1'b0, 3'b001);
        run_seq("ack_early", 3'b010,  0, 82, 1'b1, 3'b010);
        run_seq("ack_late",  3'b100, 65, 82, 1'b1, 3'b100);

        // Two requesters held high continuously take turns
        go_idle();
        req = 3'b011;
        got = 0;
        for (int i = 0; i < 2000 && got < 4; i++) begin
            resettaken = ($urandom_range(0, 3) == 0);
            tick();
            if (pio_chipselect && !pio_write_n && pio_writedata[0]) begin
                chk("alt_grant", 32'(grant), 32'(alt_exp[got]));
                got++;
            end
        end
        chk("alt_count", 32'(got), 32'd4);

        // Reset while holding: bus idles immediately, no release write
        go_idle();
        req = 3'b010;
        tick();
        a = cyc;
        for (int i = 0; i < 8; i++) begin
            resettaken = (cyc == a + 3);
            tick();
        end
        resettaken = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_cs", 32'(pio_chipselect), 32'd0);
        chk("mid_rst_wn", 32'(pio_write_n), 32'd1);
        chk("mid_rst_wd", pio_writedata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("in_rst_cs", 32'(pio_chipselect), 32'd0);
            chk("in_rst_done", 32'(done), 32'd0);
        end
        reset = 1'b0;
        model_reset();
        tick();
        chk("post_rst_grant", 32'(grant), 32'b010);

        // Random requesters and acknowledges against the model
        rq_hold = 3'b010;
        rt_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (done[IW'(j)]) rq_hold[IW'(j)] = 1'($urandom_range(0, 1));
                else if (!rq_hold[IW'(j)] && $urandom_range(0, 7) == 0) rq_hold[IW'(j)] = 1'b1;
            end
            if (m_active && m_elapsed == 0) rt_mode = int'($urandom_range(0, 3));
            req        = rq_hold;
            resettaken = (rt_mode != 0) && ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
